// File: rtl/cpu_pkg.sv
`default_nettype none
// cpu_pkg: shared encodings for the ALU and the branch/PC unit.
package cpu_pkg;

  localparam int WORD_W = 32;

  localparam logic [1:0] BR_NOP  = 2'b00;
  localparam logic [1:0] BR_JUMP = 2'b01;
  localparam logic [1:0] BR_BRZ  = 2'b10;
  localparam logic [1:0] BR_BRN  = 2'b11;

  localparam logic [2:0] ALU_ADD    = 3'b100;
  localparam logic [2:0] ALU_NEG    = 3'b010;
  localparam logic [2:0] ALU_SUB    = 3'b001;
  localparam logic [2:0] ALU_PASS_A = 3'b111;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/branch_cond_eval.sv
`default_nettype none
// branch_cond_eval: decides whether a branch opcode is taken given the effective Z/N flags.
module branch_cond_eval
  import cpu_pkg::*;
(
  input  logic [1:0] br_op,
  input  logic       eff_z,
  input  logic       eff_n,
  output logic       take
);

  always_comb begin
    take = 1'b0;
    case (br_op)
      BR_NOP:  take = 1'b0;
      BR_JUMP: take = 1'b1;
      BR_BRZ:  take = eff_z;
      BR_BRN:  take = eff_n;
      default: take = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// branch_resolve_unit: owns the PC and Z/N flag register, resolves branches and
// raises a fixed-length fetch/decode flush window after every taken branch.
module branch_resolve_unit
  import cpu_pkg::*;
#(
  parameter int                FLUSH_CYCLES = 2,
  parameter logic [WORD_W-1:0] RESET_PC     = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flag_we,
  input  logic              alu_z,
  input  logic              alu_n,
  input  logic              pc_en,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [1:0]        br_op,
  input  logic [WORD_W-1:0] br_target,
  output logic [WORD_W-1:0] pc,
  output logic              taken,
  output logic              flush,
  output logic              z_q,
  output logic              n_q
);

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       eff_z;
  logic       eff_n;
  logic       take;

  // Forward the flags being written this cycle so a branch sees them immediately.
  assign eff_z    = flag_we ? alu_z : z_q;
  assign eff_n    = flag_we ? alu_n : n_q;
  assign br_ready = (state == ST_IDLE);

  branch_cond_eval u_cond (
    .br_op (br_op),
    .eff_z (eff_z),
    .eff_n (eff_n),
    .take  (take)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
      pc    <= RESET_PC;
      z_q   <= 1'b0;
      n_q   <= 1'b0;
      taken <= 1'b0;
      flush <= 1'b0;
    end else begin
      if (flag_we) begin
        z_q <= alu_z;
        n_q <= alu_n;
      end
      taken <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (br_valid && take) begin
            pc    <= br_target;
            taken <= 1'b1;
            flush <= 1'b1;
            cnt   <= FLUSH_INIT;
            state <= ST_FLUSH;
          end else if (pc_en) begin
            pc <= pc + 32'd1;
          end
        end
        ST_FLUSH: begin
          if (pc_en) begin
            pc <= pc + 32'd1;
          end
          if (cnt == 4'd0) begin
            flush <= 1'b0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// tb_branch_resolve_unit: directed scenarios plus randomized traffic against a behavioural model.
module tb_branch_resolve_unit;

  localparam int          FC  = 2;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flag_we = 1'b0, alu_z = 1'b0, alu_n = 1'b0, pc_en = 1'b0, br_valid = 1'b0;
  logic [1:0]  br_op = 2'b00;
  logic [31:0] br_target = 32'h0;
  logic        br_ready, taken, flush, z_q, n_q;
  logic [31:0] pc;

  int errors = 0;
  int checks = 0;

  // Behavioural model: flush window as a count of remaining high cycles.
  logic [31:0] m_pc = RPC;
  logic        m_z = 1'b0, m_n = 1'b0, m_taken = 1'b0;
  int          m_fl = 0;

  branch_resolve_unit #(.FLUSH_CYCLES(FC), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .flag_we(flag_we), .alu_z(alu_z), .alu_n(alu_n),
    .pc_en(pc_en), .br_valid(br_valid), .br_ready(br_ready), .br_op(br_op),
    .br_target(br_target), .pc(pc), .taken(taken), .flush(flush), .z_q(z_q), .n_q(n_q)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic fw, input logic z, input logic n, input logic pe,
                       input logic bv, input logic [1:0] op, input logic [31:0] tgt);
    flag_we = fw; alu_z = z; alu_n = n; pc_en = pe; br_valid = bv; br_op = op; br_target = tgt;
  endtask

  task automatic model_reset();
    m_pc = RPC; m_z = 1'b0; m_n = 1'b0; m_taken = 1'b0; m_fl = 0;
  endtask

  // One clock edge; the model is advanced from the inputs held across the edge.
  task automatic tick();
    logic ez, en, tk, acc;
    ez  = flag_we ? alu_z : m_z;
    en  = flag_we ? alu_n : m_n;
    tk  = (br_op == 2'b01) || (br_op == 2'b10 && ez) || (br_op == 2'b11 && en);
    acc = br_valid && (m_fl == 0);
    @(posedge clk);
    m_taken = 1'b0;
    if (m_fl > 0) begin
      m_fl = m_fl - 1;
      if (pc_en) m_pc = m_pc + 32'd1;
    end else if (acc && tk) begin
      m_pc = br_target; m_taken = 1'b1; m_fl = FC;
    end else if (pc_en) begin
      m_pc = m_pc + 32'd1;
    end
    if (flag_we) begin m_z = alu_z; m_n = alu_n; end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    model_reset();
    #1;
    checks++; if (pc !== RPC) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pc, RPC); end
    checks++; if ({flush, taken, br_ready, z_q, n_q} !== 5'b00100) begin
      errors++; $display("FAIL reset_outs got=%b exp=00100", {flush, taken, br_ready, z_q, n_q});
    end
    drive(0, 0, 0, 1, 0, 2'b00, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (pc !== 32'(i)) begin errors++; $display("FAIL count_pc got=%h exp=%h", pc, i); end
    end
    checks++; if ({flush, taken, br_ready} !== 3'b001) begin
      errors++; $display("FAIL count_ctrl got=%b exp=001", {flush, taken, br_ready});
    end
  endtask

  task automatic test_brz_taken();
    drive(1, 1, 0, 0, 0, 2'b00, 32'h0); tick();
    checks++; if (z_q !== 1'b1) begin errors++; $display("FAIL brz_zq got=%b exp=1", z_q); end
    drive(0, 0, 0, 0, 1, 2'b10, 32'h40); tick();
    checks++; if ({pc, taken, flush, br_ready} !== {32'h40, 3'b110}) begin
      errors++; $display("FAIL brz_accept pc=%h t/f/r=%b exp pc=40 t/f/r=110", pc, {taken, flush, br_ready});
    end
    drive(0, 0, 0, 0, 0, 2'b00, 32'h0); tick();
    checks++; if ({taken, flush, br_ready} !== 3'b010) begin
      errors++; $display("FAIL brz_flush1 got=%b exp=010", {taken, flush, br_ready});
    end
    tick();
    checks++; if ({taken, flush, br_ready, pc} !== {3'b001, 32'h40}) begin
      errors++; $display("FAIL brz_done t/f/r=%b pc=%h exp 001 pc=40", {taken, flush, br_ready}, pc);
    end
  endtask

  task automatic test_brn_forward();
    drive(1, 0, 0, 0, 0, 2'b00, 32'h0); tick();
    checks++; if (n_q !== 1'b0) begin errors++; $display("FAIL fwd_nq_pre got=%b exp=0", n_q); end
    drive(1, 0, 1, 0, 1, 2'b11, 32'h80); tick();
    checks++; if ({pc, taken, n_q} !== {32'h80, 2'b11}) begin
      errors++; $display("FAIL fwd_brn pc=%h taken=%b n_q=%b exp pc=80 1 1", pc, taken, n_q);
    end
    drive(0, 0, 0, 0, 0, 2'b00, 32'h0); tick(); tick();
  endtask

  task automatic test_not_taken();
    drive(1, 0, 0, 0, 1, 2'b01, 32'h5); tick();
    drive(0, 0, 0, 0, 0, 2'b00, 32'h0); tick(); tick();
    checks++; if ({pc, z_q, br_ready} !== {32'h5, 2'b01}) begin
      errors++; $display("FAIL nt_setup pc=%h z_q=%b rdy=%b exp pc=5 0 1", pc, z_q, br_ready);
    end
    drive(0, 0, 0, 1, 1, 2'b10, 32'h99); tick();
    checks++; if ({pc, taken, br_ready} !== {32'h6, 2'b01}) begin
      errors++; $display("FAIL nt_brz pc=%h taken=%b rdy=%b exp pc=6 0 1", pc, taken, br_ready);
    end
    drive(0, 0, 0, 1, 1, 2'b01, 32'h10); tick();
    checks++; if ({pc, taken} !== {32'h10, 1'b1}) begin
      errors++; $display("FAIL nt_jump pc=%h taken=%b exp pc=10 1", pc, taken);
    end
    drive(0, 0, 0, 0, 0, 2'b00, 32'h0); tick(); tick();
  endtask

  task automatic test_back_to_back();
    drive(0, 0, 0, 0, 1, 2'b01, 32'h100); tick();
    drive(0, 0, 0, 0, 1, 2'b01, 32'h200); tick();
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL b2b_ignored1 got=%h exp=100", pc); end
    tick();
    checks++; if ({pc, br_ready} !== {32'h100, 1'b1}) begin
      errors++; $display("FAIL b2b_ignored2 pc=%h rdy=%b exp pc=100 1", pc, br_ready);
    end
    tick();
    checks++; if ({pc, taken} !== {32'h200, 1'b1}) begin
      errors++; $display("FAIL b2b_accept pc=%h taken=%b exp pc=200 1", pc, taken);
    end
    drive(0, 0, 0, 0, 0, 2'b00, 32'h0); tick(); tick();
  endtask

  task automatic test_wrap_and_async_reset();
    drive(0, 0, 0, 0, 1, 2'b01, 32'hFFFF_FFFF); tick();
    drive(0, 0, 0, 0, 0, 2'b00, 32'h0); tick(); tick();
    drive(0, 0, 0, 1, 0, 2'b00, 32'h0); tick();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap got=%h exp=0", pc); end
    drive(0, 0, 0, 0, 1, 2'b01, 32'h55); tick();
    drive(0, 0, 0, 0, 0, 2'b00, 32'h0);
    #2 rst = 1'b1;
    #1;
    checks++; if ({pc, flush, br_ready} !== {RPC, 2'b01}) begin
      errors++; $display("FAIL async_rst pc=%h flush=%b rdy=%b exp pc=%h 0 1", pc, flush, br_ready, RPC);
    end
    @(posedge clk); #2 rst = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) < 3), 1'($urandom), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 1) == 1), 2'($urandom), $urandom);
      tick();
      checks++; if (pc !== m_pc) begin errors++; $display("FAIL rnd_pc cyc=%0d got=%h exp=%h", i, pc, m_pc); end
      checks++; if ({taken, flush, br_ready} !== {m_taken, (m_fl > 0), (m_fl == 0)}) begin
        errors++; $display("FAIL rnd_ctrl cyc=%0d got=%b exp=%b", i, {taken, flush, br_ready},
                           {m_taken, (m_fl > 0), (m_fl == 0)});
      end
      checks++; if ({z_q, n_q} !== {m_z, m_n}) begin
        errors++; $display("FAIL rnd_flags cyc=%0d got=%b exp=%b", i, {z_q, n_q}, {m_z, m_n});
      end
    end
  endtask

  initial begin
    test_reset();
    test_brz_taken();
    test_brn_forward();
    test_not_taken();
    test_back_to_back();
    test_wrap_and_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
